pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the five-stage 64-bit pipeline (IF, RF, EX, MEM, WB). It keeps a shadow pipeline of destination-register tags for the instructions in EX, MEM and WB. It compares those tags against the source registers of the instruction in RF, and from that comparison issues four things: load-use stalls, branch flushes, registered forwarding selects for the EX-stage operand muxes, and stall/flush event counts. Decode logic drives its inputs; its outputs go to the IF PC register, the IF/RF and RF/EX pipeline registers, and the EX operand muxes.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/fwd_select.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the five-stage pipeline hazard controller.
// Slot tags describe the instructions in EX, MEM and WB.
package pipe_ctrl_pkg;

  localparam logic [4:0] ZERO_REG_IDX = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // A slot can only produce a hazard if it will really write a non-zero register.
  function automatic logic is_producer(slot_t s, logic [4:0] zero_reg);
    return s.valid && s.regwrite && (s.rd != zero_reg);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand comparison of one RF-stage source against the EX and MEM slots.
// Returns the forwarding select and whether the EX-slot match is a load.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int ZERO_REG = 31
) (
  input  logic       id_valid,
  input  logic [4:0] src,
  input  logic       used,
  input  slot_t      ex_s,
  input  slot_t      mem_s,
  output fwd_sel_t   sel,
  output logic       load_hit
);

  localparam logic [4:0] ZR = ZERO_REG[4:0];

  logic compare;
  logic ex_match;
  logic mem_match;

  assign compare   = id_valid && used;
  assign ex_match  = compare && is_producer(ex_s, ZR)  && (ex_s.rd  == src);
  assign mem_match = compare && is_producer(mem_s, ZR) && (mem_s.rd == src);
  assign load_hit  = ex_match && ex_s.memread;

  // A load in MEM is already covered by forwarding, so its memread flag is irrelevant here.
  logic unused_mem_memread;
  assign unused_mem_memread = mem_s.memread;

  // NOTE: assign a default first in always_comb so no path leaves sel unassigned (no latch).
  always_comb begin
    sel = FWD_RF;
    if (ex_match)       sel = FWD_MEM;  // youngest producer wins
    else if (mem_match) sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, branch flushes,
// registered EX forwarding selects and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic             id_rn_used,
  input  logic [4:0]       id_rm,
  input  logic             id_rm_used,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             br_taken_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       fwd_a_ex,
  output logic [1:0]       fwd_b_ex,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  slot_t    ex_s, mem_s, wb_s;
  slot_t    id_slot;
  fwd_sel_t sel_a, sel_b;
  fwd_sel_t fwd_a_q, fwd_b_q;
  logic     hit_a, hit_b;
  logic     stall, flush;

  fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .id_valid (id_valid),
    .src      (id_rn),
    .used     (id_rn_used),
    .ex_s     (ex_s),
    .mem_s    (mem_s),
    .sel      (sel_a),
    .load_hit (hit_a)
  );

  fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .id_valid (id_valid),
    .src      (id_rm),
    .used     (id_rm_used),
    .ex_s     (ex_s),
    .mem_s    (mem_s),
    .sel      (sel_b),
    .load_hit (hit_b)
  );

  // Branch outranks the load-use stall; reset forces every output low.
  assign flush = br_taken_ex && !reset;
  assign stall = (hit_a || hit_b) && !br_taken_ex && !reset;

  assign stall_if    = stall;
  assign stall_id    = stall;
  assign bubble_ex   = stall;
  assign flush_if_id = flush;
  assign flush_id_ex = flush;
  assign fwd_a_ex    = fwd_a_q;
  assign fwd_b_ex    = fwd_b_q;

  assign id_slot = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  // The register file writes before RF reads, so the WB tag never needs forwarding.
  logic unused_wb_s;
  assign unused_wb_s = ^wb_s;

  // NOTE: sequential state uses non-blocking assignments so every slot shifts from its old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_s        <= SLOT_BUBBLE;
      mem_s       <= SLOT_BUBBLE;
      wb_s        <= SLOT_BUBBLE;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      if (stall || flush || !id_valid) ex_s <= SLOT_BUBBLE;
      else                             ex_s <= id_slot;

      if (stall || flush) begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else begin
        fwd_a_q <= sel_a;
        fwd_b_q <= sel_b;
      end

      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
